id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register with operand forwarding and load-use hazard detection for the pipelined core.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/id_ex_operand_stage_fwd_mux.sv | 54 +++++
 rtl/id_ex_operand_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the pipelined core.
//  - XLEN / RADDR datapath and register-address widths
//  - ALU control encodings driven onto alu_control
//  - fwd_sel_t: which source an operand forward mux selected
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int RADDR = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// fwd_mux: operand bypass for one source register of the EX stage.
//  Inputs : rs (source address), reg_data (registered register-file value),
//           exmem_rd/exmem_reg_write/exmem_result, memwb_rd/memwb_reg_write/memwb_data
//  Outputs: value (operand to use), sel (which source was chosen)
//  IDEX_FORWARD_EN: when undefined the mux collapses to a wire (value = reg_data)
//  and the hazard unit stalls on RAW dependencies instead.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int RADDR = riscv_pkg::RADDR
) (
    input  logic [RADDR-1:0] rs,
    input  logic [XLEN-1:0]  reg_data,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic             exmem_reg_write,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic             memwb_reg_write,
    input  logic [XLEN-1:0]  memwb_data,
    output logic [XLEN-1:0]  value,
    output fwd_sel_t         sel
);

`ifdef IDEX_FORWARD_EN
    logic exmem_hit;
    logic memwb_hit;

    // x0 is hard-wired zero, so a write to it must never be bypassed.
    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

    // EX/MEM holds the younger producer, so it wins over MEM/WB.
    always_comb begin
        value = reg_data;
        sel   = FWD_REG;
        if (exmem_hit) begin
            value = exmem_result;
            sel   = FWD_EXMEM;
        end else if (memwb_hit) begin
            value = memwb_data;
            sel   = FWD_MEMWB;
        end
    end
`else
    logic unused_fwd_inputs;

    assign value = reg_data;
    assign sel   = FWD_REG;
    assign unused_fwd_inputs = ^{rs, exmem_rd, exmem_reg_write, exmem_result,
                                 memwb_rd, memwb_reg_write, memwb_data};
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
//  Inputs : decoded ID fields (id_*), EX/MEM and MEM/WB write-back info,
//           mem_stall (hold everything), flush (kill the ID instruction)
//  Outputs: hazard_stall (comb, hold PC and IF/ID), registered EX controls,
//           alu_a/alu_b (signed view), alu_c/alu_d (same bits, unsigned view),
//           ex_store_data (forwarded rs2, independent of alu_src)
//  Update priority: mem_stall > flush > hazard_stall > load.
//  IDEX_FORWARD_EN defined  : EX/MEM and MEM/WB bypass onto the registered operands.
//  IDEX_FORWARD_EN undefined: no bypass; hazard_stall also covers RAW on the
//                             EX and EX/MEM destinations.
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int RADDR = riscv_pkg::RADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_alu_src,
    input  logic [3:0]       id_alu_ctrl,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic             exmem_reg_write,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic             memwb_reg_write,
    input  logic [XLEN-1:0]  memwb_data,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic [3:0]       alu_control,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [XLEN-1:0]  alu_c,
    output logic [XLEN-1:0]  alu_d,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg
);

    logic             valid_q,      valid_d;
    logic [3:0]       alu_ctrl_q,   alu_ctrl_d;
    logic [RADDR-1:0] rs1_q,        rs1_d;
    logic [RADDR-1:0] rs2_q,        rs2_d;
    logic [XLEN-1:0]  rs1_data_q,   rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q,   rs2_data_d;
    logic [XLEN-1:0]  imm_q,        imm_d;
    logic             alu_src_q,    alu_src_d;
    logic [RADDR-1:0] rd_q,         rd_d;
    logic             reg_write_q,  reg_write_d;
    logic             mem_read_q,   mem_read_d;
    logic             mem_write_q,  mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;

    logic [XLEN-1:0]  fwd_rs1;
    logic [XLEN-1:0]  fwd_rs2;
    fwd_sel_t         rs1_sel;
    fwd_sel_t         rs2_sel;
    logic             unused_sel;

    logic             ex_hit;
    logic             load_use;
    logic             raw_stall;

    // ------------------------------------------------------------------
    // Hazard detection (looks at the ID sources against the EX occupant)
    // ------------------------------------------------------------------
    assign ex_hit   = (rd_q != '0) && ((rd_q == id_rs1) || (rd_q == id_rs2));
    assign load_use = valid_q && mem_read_q && ex_hit;

`ifdef IDEX_FORWARD_EN
    assign raw_stall = 1'b0;
`else
    // Without bypassing, any producer still in EX or EX/MEM must retire to
    // MEM/WB first; the register file's write-before-read covers the rest.
    logic exmem_hit_id;
    assign exmem_hit_id = exmem_reg_write && (exmem_rd != '0) &&
                          ((exmem_rd == id_rs1) || (exmem_rd == id_rs2));
    assign raw_stall = (valid_q && reg_write_q && ex_hit) || exmem_hit_id;
`endif

    assign hazard_stall = (load_use || raw_stall) && id_valid && !flush && !mem_stall;

    // ------------------------------------------------------------------
    // Next-state for the ID/EX register
    // ------------------------------------------------------------------
    always_comb begin
        valid_d      = valid_q;
        alu_ctrl_d   = alu_ctrl_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        alu_src_d    = alu_src_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (mem_stall) begin
            // hold: defaults already keep every register
        end else if (flush || hazard_stall) begin
            // Bubble clears rs addresses too, so it can never match a bypass.
            valid_d      = 1'b0;
            alu_ctrl_d   = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rs1_data_d   = '0;
            rs2_data_d   = '0;
            imm_d        = '0;
            alu_src_d    = 1'b0;
            rd_d         = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else begin
            valid_d      = id_valid;
            alu_ctrl_d   = id_alu_ctrl;
            rs1_d        = id_rs1;
            rs2_d        = id_rs2;
            rs1_data_d   = id_rs1_data;
            rs2_data_d   = id_rs2_data;
            imm_d        = id_imm;
            alu_src_d    = id_alu_src;
            rd_d         = id_rd;
            reg_write_d  = id_reg_write;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            mem_to_reg_d = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_ctrl_q   <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            alu_src_q    <= alu_src_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding on the registered sources
    // ------------------------------------------------------------------
    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs1 (
        .rs              (rs1_q),
        .reg_data        (rs1_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_data      (memwb_data),
        .value           (fwd_rs1),
        .sel             (rs1_sel)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs2 (
        .rs              (rs2_q),
        .reg_data        (rs2_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_data      (memwb_data),
        .value           (fwd_rs2),
        .sel             (rs2_sel)
    );

    // Selects are kept for debug visibility only.
    assign unused_sel = ^{rs1_sel, rs2_sel};

    // ------------------------------------------------------------------
    // EX-stage outputs
    // ------------------------------------------------------------------
    assign ex_valid      = valid_q;
    assign alu_control   = alu_ctrl_q;
    assign alu_a         = fwd_rs1;
    assign alu_b         = alu_src_q ? imm_q : fwd_rs2;
    assign alu_c         = alu_a;
    assign alu_d         = alu_b;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage. Expectations follow the build:
// IDEX_FORWARD_EN defined -> bypass checks; undefined -> 2-cycle RAW stalls.
module tb_id_ex_operand_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [63:0] exmem_result, memwb_data;
    logic        mem_stall, flush;
    logic        hazard_stall, ex_valid;
    logic [3:0]  alu_control;
    logic [63:0] alu_a, alu_b, alu_c, alu_d, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .mem_stall(mem_stall), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_control(alu_control),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Move one clock forward and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_alu_src = 0; id_alu_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_data = 0;
        mem_stall = 0; flush = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [63:0] d1, input logic [63:0] d2,
                          input logic [3:0] ctrl, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = 0; id_alu_src = 0;
        id_alu_ctrl = ctrl; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = 0; id_mem_to_reg = mr;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        #12;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_ex_rd", ex_rd, 0);
        rst_n = 1;

        // ---- reset mid-stream ----
        set_id(5'd1, 5'd2, 64'h11, 64'h22, ALU_ADD, 5'd9, 1, 0);
        tick();
        chk("load_ex_valid", ex_valid, 1);
        chk("load_alu_a", alu_a, 64'h11);
        chk("load_alu_b", alu_b, 64'h22);
        chk("load_ex_rd", ex_rd, 9);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_alu_a", alu_a, 0);
        chk("async_rst_alu_b", alu_b, 0);
        chk("async_rst_rd", ex_rd, 0);
        chk("async_rst_rw", ex_reg_write, 0);
        chk("async_rst_ctrl", alu_control, 0);
        rst_n = 1;
        idle_in();
        tick();

        // ---- x0 never forwarded / never stalls ----
        set_id(5'd0, 5'd0, 64'h0, 64'h0, ALU_ADD, 5'd10, 1, 0);
        exmem_rd = 0; exmem_reg_write = 1; exmem_result = 64'hFFFF;
        #1 chk("x0_no_stall", hazard_stall, 0);
        tick();
        chk("x0_alu_a", alu_a, 0);
        chk("x0_valid", ex_valid, 1);
        idle_in();
        tick();

        // ---- immediate operand, store data, unsigned copies ----
        set_id(5'd11, 5'd12, 64'h77, 64'h55, ALU_SUB, 5'd13, 1, 0);
        id_alu_src = 1; id_imm = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        chk("imm_alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("imm_alu_d", alu_d, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("imm_alu_c", alu_c, 64'h77);
        chk("imm_store", ex_store_data, 64'h55);
        chk("imm_ctrl", alu_control, ALU_SUB);
        idle_in();
        tick();

        // ---- add x3,x1,x2 ; sub x4,x3,x1 ----
        set_id(5'd1, 5'd2, 64'h5, 64'h6, ALU_ADD, 5'd3, 1, 0);
        tick();
        set_id(5'd3, 5'd1, 64'h99, 64'h5, ALU_SUB, 5'd4, 1, 0);
        #1;
`ifdef IDEX_FORWARD_EN
        chk("raw_no_stall", hazard_stall, 0);
        tick();
        idle_in();
        exmem_rd = 3; exmem_reg_write = 1; exmem_result = 64'h10;
        #1 chk("fwd_exmem", alu_a, 64'h10);
        memwb_rd = 3; memwb_reg_write = 1; memwb_data = 64'h20;
        #1 chk("fwd_exmem_prio", alu_a, 64'h10);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", alu_a, 64'h20);
        memwb_reg_write = 0;
        #1 chk("fwd_none", alu_a, 64'h99);
        chk("fwd_store_rs2", ex_store_data, 64'h5);
`else
        chk("raw_stall1", hazard_stall, 1);
        tick();
        chk("raw_bubble1", ex_valid, 0);
        exmem_rd = 3; exmem_reg_write = 1; exmem_result = 64'h10;
        #1 chk("raw_stall2", hazard_stall, 1);
        tick();
        chk("raw_bubble2", ex_valid, 0);
        exmem_reg_write = 0; exmem_rd = 0;
        memwb_rd = 3; memwb_reg_write = 1; memwb_data = 64'h10;
        id_rs1_data = 64'h10;
        #1 chk("raw_released", hazard_stall, 0);
        tick();
        chk("raw_enter_valid", ex_valid, 1);
        chk("raw_enter_alu_a", alu_a, 64'h10);
        chk("raw_enter_ctrl", alu_control, ALU_SUB);
`endif
        idle_in();
        tick();

        // ---- ld x5 ; add x6,x5,x7 ----
        set_id(5'd8, 5'd0, 64'h100, 64'h0, ALU_ADD, 5'd5, 1, 1);
        tick();
        chk("ld_in_ex", ex_mem_read, 1);
        set_id(5'd5, 5'd7, 64'hDEAD, 64'h7, ALU_ADD, 5'd6, 1, 0);
        #1 chk("lu_stall", hazard_stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_mr", ex_mem_read, 0);
        exmem_rd = 5; exmem_reg_write = 1; exmem_result = 64'h100;
`ifdef IDEX_FORWARD_EN
        #1 chk("lu_one_cycle", hazard_stall, 0);
        tick();
        exmem_rd = 0; exmem_reg_write = 0;
        memwb_rd = 5; memwb_reg_write = 1; memwb_data = 64'hABC;
        #1 chk("lu_fwd_alu_a", alu_a, 64'hABC);
        chk("lu_fwd_valid", ex_valid, 1);
`else
        #1 chk("lu_stall2", hazard_stall, 1);
        tick();
        chk("lu_bubble2", ex_valid, 0);
        exmem_rd = 0; exmem_reg_write = 0;
        memwb_rd = 5; memwb_reg_write = 1; memwb_data = 64'hABC;
        id_rs1_data = 64'hABC;
        #1 chk("lu_released", hazard_stall, 0);
        tick();
        chk("lu_enter_alu_a", alu_a, 64'hABC);
        chk("lu_enter_valid", ex_valid, 1);
`endif
        idle_in();
        tick();

        // ---- mem_stall beats flush and hazard; then flush bubbles ----
        set_id(5'd1, 5'd0, 64'h33, 64'h0, ALU_ADD, 5'd7, 1, 1);
        tick();
        set_id(5'd7, 5'd0, 64'h44, 64'h0, ALU_OR, 5'd8, 1, 0);
        #1 chk("ms_hazard_ref", hazard_stall, 1);
        mem_stall = 1; flush = 1;
        #1 chk("ms_no_stall", hazard_stall, 0);
        tick();
        chk("ms_hold_valid", ex_valid, 1);
        chk("ms_hold_alu_a", alu_a, 64'h33);
        chk("ms_hold_rd", ex_rd, 7);
        chk("ms_hold_mr", ex_mem_read, 1);
        mem_stall = 0;
        #1 chk("fl_no_stall", hazard_stall, 0);
        tick();
        chk("fl_bubble_valid", ex_valid, 0);
        chk("fl_bubble_alu_a", alu_a, 0);
        chk("fl_bubble_rd", ex_rd, 0);
        chk("fl_bubble_rw", ex_reg_write, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
